random_gen: RTL and testbench
=============================

Name: random_gen

Overview:
- Pseudo-random number source for the game FSM. Supplies layout direction, colour and jump-distance jitter.
- Implements a maximal-length 16-bit Fibonacci LFSR, advanced on request.
- Consumers mask the low bits they need from the output word (&1, &3'b111, &4'b1111).
- Sits beside the game FSM in the same clock domain.

Parameters:
- WIDTH, 16, LFSR state and output width; only 16 is supported.
- SEED, 16'hACE1, reset and reload value; must be nonzero.
- STEPS, 1, number of LFSR shifts applied per enabled cycle (1..WIDTH).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  advance request; when high, state advances STEPS shifts on the next clock edge.
- load  input  1  synchronous seed load.
- seed_in  input  WIDTH  seed value used when load=1.
- rnd  output  WIDTH  current LFSR state, registered.
- lockup  output  1  one-cycle pulse, high in the cycle after an all-zero state was detected and corrected.

Behaviour:
- Reset (asynchronous on rst=1): state = SEED (0xACE1), lockup = 0. Both outputs hold their reset values while rst is high.
- Single shift function, given state s:
  - fb = s[0] ^ s[2] ^ s[3] ^ s[5]
  - s' = {fb, s[15:1]} (shift right, feedback into MSB)
  - polynomial x^16+x^14+x^13+x^11+1; period 65535.
- Per clock edge, priority order:
  - load=1: state = (seed_in==0) ? SEED : seed_in. The en input is ignored that cycle.
  - otherwise en=1: state = shift applied STEPS times, combinationally unrolled, one clock edge of latency.
  - otherwise: state holds.
- rnd always equals the state register. A value changes exactly one cycle after the en/load edge; there is no combinational path from en to rnd.
- Lockup guard:
  - If the state register is ever 0 (only possible through SEU or a bad forced value), the next edge loads SEED regardless of en.
  - lockup = 1 for that one cycle, else 0.
  - This takes precedence below rst and above load.
- Reset asserted mid-operation overrides everything immediately. The state restarts from SEED, so the sequence is deterministic after every reset.
- Known sequence, STEPS=1, SEED=0xACE1: 0xACE1 -> 0x5670 -> 0xAB38 -> ...
- Low bit fields of rnd are the consumer's responsibility. No output masking is done in this block.
- No handshake: any number of consecutive en cycles is legal, one advance per cycle.

Decomposition:
- Shared package `random_pkg`:
  - constants RANDOM_WIDTH=16 and RANDOM_SEED=16'hACE1
  - tap mask 16'h002D (bits 0, 2, 3, 5)
  - a pure function lfsr_step(s) returning the single-shift next state, reused by the RTL and the bench reference model
- No sub-module needed. The STEPS unroll is a generate loop over lfsr_step inside random_gen.

Test Plan:
- Reset then idle: assert rst asynchronously mid-cycle -> rnd = 0xACE1 immediately. Hold en=0 for 10 cycles -> rnd stays 0xACE1, lockup=0.
- Advance: en=1 for 2 cycles after reset -> rnd = 0x5670 after first edge, 0xAB38 after second. Compare 1000 consecutive steps against the lfsr_step model.
- Period: en=1 continuously from reset -> rnd returns to 0xACE1 after exactly 65535 advances and never equals 0 before that.
- Load: load=1, seed_in=0x1234 -> rnd=0x1234 next edge; then en=1 -> rnd = lfsr_step(0x1234) = 0x091A. Load with seed_in=0 -> rnd=0xACE1. Load and en asserted together -> load wins.
- Lockup: force state to 0 for one cycle -> next edge rnd=0xACE1 and lockup=1 for exactly one cycle.
- Reset mid-stream: run en=1 for 37 cycles, assert rst -> rnd=0xACE1. After release, the sequence repeats from 0x5670.

Source files
------------

// File: rtl/random_gen_pkg.sv
// Shared constants, update-source encoding and the single-shift LFSR function
// used by the random number source.
package random_pkg;

  localparam int unsigned      RANDOM_WIDTH = 16;
  localparam logic [15:0]      RANDOM_SEED  = 16'hACE1;
  // Feedback taps: bits 0, 2, 3, 5 (x^16 + x^14 + x^13 + x^11 + 1).
  localparam logic [15:0]      RANDOM_TAPS  = 16'h002D;

  // Which source updates the state register on the next edge.
  typedef enum logic [1:0] {
    UPD_HOLD,
    UPD_STEP,
    UPD_LOAD,
    UPD_RECOVER
  } upd_sel_e;

  // One Fibonacci shift: feedback into the MSB, shift right.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic fb;
    fb = ^(s & RANDOM_TAPS);
    return {fb, s[15:1]};
  endfunction

endpackage

// File: rtl/random_gen_if.sv
// Request/response bundle between the game FSM (master) and the random
// number source (slave).
interface random_gen_if
  import random_pkg::*;
#(
  parameter int unsigned WIDTH = RANDOM_WIDTH
);

  logic             en;
  logic             load;
  logic [WIDTH-1:0] seed_in;
  logic [WIDTH-1:0] rnd;
  logic             lockup;

  modport master (
    output en,
    output load,
    output seed_in,
    input  rnd,
    input  lockup
  );

  modport slave (
    input  en,
    input  load,
    input  seed_in,
    output rnd,
    output lockup
  );

endinterface

// File: rtl/random_gen.sv
// 16-bit maximal-length Fibonacci LFSR, advanced STEPS shifts per enabled
// cycle, with synchronous seed load and all-zero lockup recovery.
module random_gen
  import random_pkg::*;
#(
  parameter int unsigned      WIDTH = RANDOM_WIDTH,
  parameter logic [WIDTH-1:0] SEED  = RANDOM_SEED,
  parameter int unsigned      STEPS = 1
) (
  input  logic         clk,
  input  logic         rst,
  random_gen_if.slave  bus
);

  // Reject configurations the tap set and unroll cannot honour.
  if (WIDTH != RANDOM_WIDTH) begin : g_bad_width
    $error("random_gen: only WIDTH=16 is supported");
  end
  if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
    $error("random_gen: STEPS must be in 1..WIDTH");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("random_gen: SEED must be nonzero");
  end

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] state_next;
  logic [WIDTH-1:0] step_next;
  logic [WIDTH-1:0] load_value;
  logic             lockup_q;
  upd_sel_e         upd_sel;

  // STEPS shifts chained combinationally; each stage feeds the next.
  for (genvar g = 0; g < STEPS; g++) begin : g_unroll
    logic [WIDTH-1:0] s;
    if (g == 0) begin : g_first
      assign s = lfsr_step(state);
    end else begin : g_next
      assign s = lfsr_step(g_unroll[g-1].s);
    end
  end

  assign step_next  = g_unroll[STEPS-1].s;
  // A zero seed would lock the LFSR, so it falls back to SEED.
  assign load_value = (bus.seed_in == '0) ? SEED : bus.seed_in;

  // Priority decode of the update source: recovery, load, advance, hold.
  always_comb begin
    upd_sel = UPD_HOLD;
    if (state == '0) begin
      upd_sel = UPD_RECOVER;
    end else if (bus.load) begin
      upd_sel = UPD_LOAD;
    end else if (bus.en) begin
      upd_sel = UPD_STEP;
    end
  end

  // Next-state selection for the state register.
  always_comb begin
    state_next = state;
    unique case (upd_sel)
      UPD_RECOVER: state_next = SEED;
      UPD_LOAD:    state_next = load_value;
      UPD_STEP:    state_next = step_next;
      default:     state_next = state;
    endcase
  end

  // State register and one-cycle lockup indication.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SEED;
      lockup_q <= 1'b0;
    end else begin
      state    <= state_next;
      lockup_q <= (upd_sel == UPD_RECOVER);
    end
  end

  assign bus.rnd    = state;
  assign bus.lockup = lockup_q;

endmodule

// File: tb/tb_random_gen.sv
// Randomised self-checking bench for random_gen against an arithmetic
// reference model of the LFSR.
module tb_random_gen;

  logic clk;
  logic rst;

  int unsigned checks;
  int unsigned errors;

  int unsigned m;    // model state, STEPS=1 instance
  int unsigned m4;   // model state, STEPS=4 instance

  random_gen_if #(.WIDTH(16)) bus1 ();
  random_gen_if #(.WIDTH(16)) bus4 ();

  random_gen #(.WIDTH(16), .SEED(16'hACE1), .STEPS(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  random_gen #(.WIDTH(16), .SEED(16'hACE1), .STEPS(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference shift: new MSB = s0 ^ s2 ^ s3 ^ s5, rest shifted right.
  function automatic int unsigned ref_shift(input int unsigned s);
    int unsigned fb;
    fb = (s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 1;
    return ((s >> 1) | (fb << 15)) & 32'h0000_FFFF;
  endfunction

  function automatic int unsigned ref_next(input int unsigned s, input logic e,
                                           input logic l, input int unsigned sd,
                                           input int unsigned steps);
    int unsigned r;
    r = s;
    if (l) begin
      r = (sd == 0) ? 32'hACE1 : sd;
    end else if (e) begin
      for (int unsigned k = 0; k < steps; k++) r = ref_shift(r);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts and ends at a falling edge; one clock of the STEPS=1 instance.
  task automatic cyc(input logic e, input logic l, input logic [15:0] sd, input string tag);
    bus1.en = e; bus1.load = l; bus1.seed_in = sd;
    @(posedge clk); #1;
    m = ref_next(m, e, l, {16'h0, sd}, 1);
    check({tag, "_rnd"}, {16'h0, bus1.rnd}, m);
    check({tag, "_lock"}, {31'h0, bus1.lockup}, 32'h0);
    @(negedge clk);
  endtask

  task automatic cyc4(input logic e, input logic l, input logic [15:0] sd, input string tag);
    bus4.en = e; bus4.load = l; bus4.seed_in = sd;
    @(posedge clk); #1;
    m4 = ref_next(m4, e, l, {16'h0, sd}, 4);
    check({tag, "_rnd"}, {16'h0, bus4.rnd}, m4);
    check({tag, "_lock"}, {31'h0, bus4.lockup}, 32'h0);
    @(negedge clk);
  endtask

  int unsigned mism;
  int unsigned zeros;
  int unsigned first_ret;
  logic [15:0] rs;

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0;
    bus1.en = 1'b0; bus1.load = 1'b0; bus1.seed_in = '0;
    bus4.en = 1'b0; bus4.load = 1'b0; bus4.seed_in = '0;

    // Asynchronous reset mid-cycle, then hold through an edge with en high.
    #1 rst = 1'b1;
    #1;
    check("reset_async_rnd", {16'h0, bus1.rnd}, 32'hACE1);
    check("reset_async_lock", {31'h0, bus1.lockup}, 32'h0);
    bus1.en = 1'b1;
    @(posedge clk); #1;
    check("reset_hold_rnd", {16'h0, bus1.rnd}, 32'hACE1);
    @(negedge clk);
    bus1.en = 1'b0;
    rst = 1'b0;
    m = 32'hACE1;

    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 16'h0, "idle");

    // Known sequence from the seed.
    cyc(1'b1, 1'b0, 16'h0, "adv1");
    check("adv1_const", {16'h0, bus1.rnd}, 32'h5670);
    cyc(1'b1, 1'b0, 16'h0, "adv2");
    check("adv2_const", {16'h0, bus1.rnd}, 32'hAB38);

    // Randomised en / occasional load.
    for (int i = 0; i < 1000; i++) begin
      rs = 16'($urandom);
      if ($urandom_range(0, 31) == 0) cyc(1'($urandom), 1'b1, rs, "rand_load");
      else cyc(($urandom_range(0, 3) != 0), 1'b0, rs, "rand_step");
    end

    // Reset in the middle of a run of advances.
    for (int i = 0; i < 37; i++) cyc(1'b1, 1'b0, 16'h0, "run37");
    #2 rst = 1'b1;
    #1;
    check("midrst_rnd", {16'h0, bus1.rnd}, 32'hACE1);
    check("midrst_lock", {31'h0, bus1.lockup}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    m = 32'hACE1;
    cyc(1'b1, 1'b0, 16'h0, "post_rst1");
    check("post_rst1_const", {16'h0, bus1.rnd}, 32'h5670);
    cyc(1'b1, 1'b0, 16'h0, "post_rst2");
    check("post_rst2_const", {16'h0, bus1.rnd}, 32'hAB38);

    // Load behaviour, including load beating en and the zero-seed fallback.
    cyc(1'b1, 1'b1, 16'h1234, "load_en");
    check("load_en_const", {16'h0, bus1.rnd}, 32'h1234);
    cyc(1'b1, 1'b0, 16'h0, "load_step");
    check("load_step_const", {16'h0, bus1.rnd}, 32'h091A);
    cyc(1'b0, 1'b1, 16'h0000, "load_zero");
    check("load_zero_const", {16'h0, bus1.rnd}, 32'hACE1);
    cyc(1'b0, 1'b1, 16'hFFFF, "load_ones");
    cyc(1'b1, 1'b0, 16'h0, "ones_step");

    // Lockup guard: zero state recovers to SEED even against a load.
    force dut.state = '0;
    bus1.en = 1'b1; bus1.load = 1'b1; bus1.seed_in = 16'h1234;
    #1;
    check("forced_zero_lock", {31'h0, bus1.lockup}, 32'h0);
    #3 release dut.state;
    @(posedge clk); #1;
    m = 32'hACE1;
    check("lockup_rnd", {16'h0, bus1.rnd}, 32'hACE1);
    check("lockup_pulse", {31'h0, bus1.lockup}, 32'h1);
    @(negedge clk);
    cyc(1'b0, 1'b0, 16'h0, "lockup_after");
    cyc(1'b1, 1'b0, 16'h0, "lockup_resume");

    // Lockup pulse cleared immediately by reset.
    force dut.state = '0;
    bus1.en = 1'b0; bus1.load = 1'b0;
    #4 release dut.state;
    @(posedge clk); #1;
    check("lockup2_pulse", {31'h0, bus1.lockup}, 32'h1);
    #1 rst = 1'b1;
    #1;
    check("lockup2_rst", {31'h0, bus1.lockup}, 32'h0);
    check("lockup2_rst_rnd", {16'h0, bus1.rnd}, 32'hACE1);
    @(negedge clk);
    rst = 1'b0;
    m = 32'hACE1;

    // Full period with continuous en.
    mism = 0; zeros = 0; first_ret = 0;
    bus1.en = 1'b1; bus1.load = 1'b0;
    for (int unsigned i = 1; i <= 65535; i++) begin
      @(posedge clk); #1;
      m = ref_shift(m);
      if (32'(bus1.rnd) != m) mism++;
      if (bus1.rnd == 16'h0) zeros++;
      if (bus1.rnd == 16'hACE1 && first_ret == 0) first_ret = i;
    end
    @(negedge clk);
    bus1.en = 1'b0;
    check("period_model", mism, 32'h0);
    check("period_nozero", zeros, 32'h0);
    check("period_len", first_ret, 32'd65535);
    check("period_end_rnd", {16'h0, bus1.rnd}, 32'hACE1);

    // STEPS=4 instance: idle since last reset, then randomised operation.
    m4 = 32'hACE1;
    check("s4_reset_rnd", {16'h0, bus4.rnd}, 32'hACE1);
    cyc4(1'b1, 1'b0, 16'h0, "s4_adv");
    for (int i = 0; i < 40; i++) begin
      rs = 16'($urandom);
      if ($urandom_range(0, 7) == 0) cyc4(1'($urandom), 1'b1, rs, "s4_load");
      else cyc4(($urandom_range(0, 3) != 0), 1'b0, rs, "s4_step");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
